// File: rtl/rgb_frame_loader_if.sv
// rtl/rgb_frame_loader_if.sv - pixel stream, frame-buffer write and frame handshake bundle
interface rgb_frame_loader_if #(
  parameter int ADDR_W = 12
);
  logic              in_valid;
  logic              in_ready;
  logic              in_sof;
  logic [7:0]        red;
  logic [7:0]        green;
  logic [7:0]        blue;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [7:0]        wr_data;
  logic              frame_ready;
  logic              frame_ack;
  logic              sof_err;

  modport slave (
    input  in_valid, in_sof, red, green, blue, frame_ack,
    output in_ready, wr_en, wr_addr, wr_data, frame_ready, sof_err
  );

  modport master (
    output in_valid, in_sof, red, green, blue, frame_ack,
    input  in_ready, wr_en, wr_addr, wr_data, frame_ready, sof_err
  );
endinterface

// File: rtl/rgb_frame_loader.sv
// rtl/rgb_frame_loader.sv - RGB stream to 8-bit intensity frame loader; macro RGB_LOADER_LUMA_EN enables luma weighting
module rgb_frame_loader #(
  parameter int IMAGEX = 64,
  parameter int IMAGEY = 64,
  parameter int ADDR_W = 12
) (
  input  logic                clk,
  input  logic                rst,
  rgb_frame_loader_if.slave   bus
);

  localparam int NPIX = IMAGEX * IMAGEY;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NPIX - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_DRAIN,
    ST_FULL
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              sof_err_q, sof_err_d;

  // beat register: the accepted pixel and its address
  logic              bv_q, bv_d;
  logic [ADDR_W-1:0] b_addr_q, b_addr_d;
  logic [7:0]        b_red_q, b_red_d;

  // stage 1: products (or raw red) and address
  logic              s1_valid_q, s1_valid_d;
  logic [ADDR_W-1:0] s1_addr_q, s1_addr_d;

  // stage 2: frame-buffer write port
  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [7:0]        wr_data_q, wr_data_d;

  logic              in_ready;
  logic              accept;
  logic [ADDR_W-1:0] pix_addr;

`ifdef RGB_LOADER_LUMA_EN
  logic [7:0]  b_green_q, b_green_d;
  logic [7:0]  b_blue_q, b_blue_d;
  logic [15:0] s1_pr_q, s1_pr_d;
  logic [15:0] s1_pg_q, s1_pg_d;
  logic [15:0] s1_pb_q, s1_pb_d;
  logic [15:0] luma_sum;
`else
  logic [7:0]  s1_red_q, s1_red_d;
`endif

  assign in_ready        = !rst && (state_q == ST_IDLE || state_q == ST_LOAD);
  assign accept          = bus.in_valid && in_ready;
  assign bus.in_ready    = in_ready;
  assign bus.wr_en       = wr_en_q;
  assign bus.wr_addr     = wr_addr_q;
  assign bus.wr_data     = wr_data_q;
  assign bus.frame_ready = (state_q == ST_FULL);
  assign bus.sof_err     = sof_err_q;

  // frame sequencing: pixel counter, sof restarts, drain and buffer hand-off
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    sof_err_d = sof_err_q;
    bv_d      = 1'b0;
    pix_addr  = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (accept && bus.in_sof) begin
          bv_d     = 1'b1;
          pix_addr = '0;
          cnt_d    = ADDR_W'(1);
          state_d  = ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (accept) begin
          bv_d = 1'b1;
          if (bus.in_sof) begin
            pix_addr  = '0;
            cnt_d     = ADDR_W'(1);
            sof_err_d = 1'b1;
          end else begin
            pix_addr = cnt_q;
            cnt_d    = cnt_q + ADDR_W'(1);
            if (cnt_q == LAST_ADDR) begin
              state_d = ST_DRAIN;
            end
          end
        end
      end
      ST_DRAIN: begin
        // the final write is already on the port once the upstream stages are empty
        if (!bv_q && !s1_valid_q) begin
          state_d = ST_FULL;
        end
      end
      ST_FULL: begin
        if (bus.frame_ack) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // datapath next values: capture on valid, otherwise hold
  always_comb begin
    b_addr_d   = accept ? pix_addr : b_addr_q;
    b_red_d    = accept ? bus.red : b_red_q;
    s1_valid_d = bv_q;
    s1_addr_d  = bv_q ? b_addr_q : s1_addr_q;
    wr_en_d    = s1_valid_q;
    wr_addr_d  = s1_valid_q ? s1_addr_q : wr_addr_q;
`ifdef RGB_LOADER_LUMA_EN
    b_green_d  = accept ? bus.green : b_green_q;
    b_blue_d   = accept ? bus.blue : b_blue_q;
    s1_pr_d    = bv_q ? 16'd77  * {8'd0, b_red_q}   : s1_pr_q;
    s1_pg_d    = bv_q ? 16'd150 * {8'd0, b_green_q} : s1_pg_q;
    s1_pb_d    = bv_q ? 16'd29  * {8'd0, b_blue_q}  : s1_pb_q;
    luma_sum   = s1_pr_q + s1_pg_q + s1_pb_q;
    wr_data_d  = s1_valid_q ? luma_sum[15:8] : wr_data_q;
`else
    s1_red_d   = bv_q ? b_red_q : s1_red_q;
    wr_data_d  = s1_valid_q ? s1_red_q : wr_data_q;
`endif
  end

  // state and pipeline registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      sof_err_q  <= 1'b0;
      bv_q       <= 1'b0;
      b_addr_q   <= '0;
      b_red_q    <= '0;
      s1_valid_q <= 1'b0;
      s1_addr_q  <= '0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
`ifdef RGB_LOADER_LUMA_EN
      b_green_q  <= '0;
      b_blue_q   <= '0;
      s1_pr_q    <= '0;
      s1_pg_q    <= '0;
      s1_pb_q    <= '0;
`else
      s1_red_q   <= '0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      sof_err_q  <= sof_err_d;
      bv_q       <= bv_d;
      b_addr_q   <= b_addr_d;
      b_red_q    <= b_red_d;
      s1_valid_q <= s1_valid_d;
      s1_addr_q  <= s1_addr_d;
      wr_en_q    <= wr_en_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
`ifdef RGB_LOADER_LUMA_EN
      b_green_q  <= b_green_d;
      b_blue_q   <= b_blue_d;
      s1_pr_q    <= s1_pr_d;
      s1_pg_q    <= s1_pg_d;
      s1_pb_q    <= s1_pb_d;
`else
      s1_red_q   <= s1_red_d;
`endif
    end
  end

endmodule

// File: tb/tb_rgb_frame_loader.sv
// tb/tb_rgb_frame_loader.sv - scoreboard bench for rgb_frame_loader (both RGB_LOADER_LUMA_EN builds)
module tb_rgb_frame_loader;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  typedef struct {
    int addr;
    int data;
    int cyc;
  } exp_t;

  exp_t sb[$];

`ifdef RGB_LOADER_LUMA_EN
  localparam int Y_R = 76;
  localparam int Y_G = 149;
  localparam int Y_B = 28;
`else
  localparam int Y_R = 255;
  localparam int Y_G = 0;
  localparam int Y_B = 0;
`endif
  localparam int Y_W = 255;
  localparam int Y_A = 170;

  rgb_frame_loader_if #(.ADDR_W(12)) bus ();

  rgb_frame_loader #(
    .IMAGEX(64),
    .IMAGEY(64),
    .ADDR_W(12)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #10 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int ey(input int r, input int g, input int b);
`ifdef RGB_LOADER_LUMA_EN
    return (77 * r + 150 * g + 29 * b) >> 8;
`else
    return r + 0 * (g + b);
`endif
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  // drives one beat at the falling edge; it is taken at the following rising edge
  task automatic beat(input int r, input int g, input int b, input bit sof,
                      input bit exp_acc, input bit push, input int addr, input int y);
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_sof   = sof;
    bus.red      = 8'(r);
    bus.green    = 8'(g);
    bus.blue     = 8'(b);
    chk("in_ready", int'(bus.in_ready), int'(exp_acc));
    if (push) sb.push_back('{addr: addr, data: y, cyc: cyc + 3});
  endtask

  task automatic idle_cycle();
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in_sof   = 1'b0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_in_ready"}, int'(bus.in_ready), 1);
    chk({tag, "_wr_en"}, int'(bus.wr_en), 0);
    chk({tag, "_wr_addr"}, int'(bus.wr_addr), 0);
    chk({tag, "_wr_data"}, int'(bus.wr_data), 0);
    chk({tag, "_frame_ready"}, int'(bus.frame_ready), 0);
    chk({tag, "_sof_err"}, int'(bus.sof_err), 0);
  endtask

  // monitor: every write strobe must match the oldest expected write, address, data and cycle
  always @(negedge clk) begin
    if (bus.wr_en === 1'b1) begin
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL unexpected_write addr=%0d data=%0d cyc=%0d", bus.wr_addr, bus.wr_data, cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (int'(bus.wr_addr) !== e.addr || int'(bus.wr_data) !== e.data || cyc != e.cyc) begin
          bad++;
          $display("FAIL write got addr=%0d data=%0d cyc=%0d exp addr=%0d data=%0d cyc=%0d",
                   bus.wr_addr, bus.wr_data, cyc, e.addr, e.data, e.cyc);
        end
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog expired at cyc %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_sof    = 1'b0;
    bus.red       = 8'd0;
    bus.green     = 8'd0;
    bus.blue      = 8'd0;
    bus.frame_ack = 1'b0;
    rst           = 1'b1;

    repeat (3) @(negedge clk);
    chk("rst_in_ready", int'(bus.in_ready), 0);
    chk("rst_wr_en", int'(bus.wr_en), 0);
    rst = 1'b0;
    @(negedge clk);
    chk_reset_outputs("post_rst");

    // non-sof beats in IDLE are swallowed without a write
    beat(1, 2, 3, 1'b0, 1'b1, 1'b0, 0, 0);
    beat(4, 5, 6, 1'b0, 1'b1, 1'b0, 0, 0);

    // directed intensity vectors at the start of a frame
    beat(255, 0, 0, 1'b1, 1'b1, 1'b1, 0, Y_R);
    beat(0, 255, 0, 1'b0, 1'b1, 1'b1, 1, Y_G);
    beat(0, 0, 255, 1'b0, 1'b1, 1'b1, 2, Y_B);
    beat(255, 255, 255, 1'b0, 1'b1, 1'b1, 3, Y_W);
    beat(170, 170, 170, 1'b0, 1'b1, 1'b1, 4, Y_A);
    chk("sof_err_clean", int'(bus.sof_err), 0);

    for (int a = 5; a < 100; a++) begin
      beat(a * 13, a * 7 + 3, 255 - a, 1'b0, 1'b1, 1'b1, a,
           ey((a * 13) & 255, (a * 7 + 3) & 255, (255 - a) & 255));
    end

    // sof at pixel 100 restarts the frame at address 0 and flags the error
    beat(10, 20, 30, 1'b1, 1'b1, 1'b1, 0, ey(10, 20, 30));

    for (int a = 1; a < 4096; a++) begin
      beat(a & 255, (a >> 4) & 255, (a * 3) & 255, 1'b0, 1'b1, 1'b1, a,
           ey(a & 255, (a >> 4) & 255, (a * 3) & 255));
      if (a == 3) chk("sof_err_set", int'(bus.sof_err), 1);
    end

    // drain: extra beats held by the source are refused
    beat(99, 99, 99, 1'b0, 1'b0, 1'b0, 0, 0);
    chk("drain1_frame_ready", int'(bus.frame_ready), 0);
    beat(99, 99, 99, 1'b0, 1'b0, 1'b0, 0, 0);
    chk("drain2_frame_ready", int'(bus.frame_ready), 0);
    @(negedge clk);
    chk("drain3_frame_ready", int'(bus.frame_ready), 0);
    chk("drain3_in_ready", int'(bus.in_ready), 0);
    bus.frame_ack = 1'b1;
    @(negedge clk);
    bus.frame_ack = 1'b0;
    chk("full_frame_ready", int'(bus.frame_ready), 1);
    chk("full_in_ready", int'(bus.in_ready), 0);
    @(negedge clk);
    chk("full_hold_frame_ready", int'(bus.frame_ready), 1);
    chk("full_hold_in_ready", int'(bus.in_ready), 0);
    chk("sof_err_sticky", int'(bus.sof_err), 1);
    bus.frame_ack = 1'b1;
    bus.in_valid  = 1'b0;

    // first cycle after the ack: buffer released and a beat is taken at once
    beat(50, 60, 70, 1'b1, 1'b1, 1'b0, 0, 0);
    bus.frame_ack = 1'b0;
    chk("ack_frame_ready", int'(bus.frame_ready), 0);

    // reset one cycle after that accept: the in-flight beat must never be written
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in_sof   = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_in_ready", int'(bus.in_ready), 0);
    chk("mid_rst_wr_en", int'(bus.wr_en), 0);
    chk("mid_rst_frame_ready", int'(bus.frame_ready), 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk_reset_outputs("mid_rst_after");

    repeat (8) idle_cycle();
    chk("scoreboard_empty", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rgb_frame_loader.md
# rgb_frame_loader

Upstream ingest stage for the Floyd-Steinberg dither engine. Accepts a raster-order RGB pixel stream over a valid/ready handshake and converts each pixel to an 8-bit intensity. It writes that intensity into the 64x64 frame buffer the dither engine reads, then holds off further input until the engine acknowledges the completed frame.

## Interface
- IMAGEX, 64, pixels per row
- IMAGEY, 64, rows per frame
- ADDR_W, 12, frame-buffer address width; IMAGEX*IMAGEY must equal 2**ADDR_W
- clk  in  1  system clock (50 MHz); one clock domain
- rst  in  1  reset, synchronous, active-high
- in_valid  in  1  input beat valid
- in_ready  out  1  loader can accept a beat
- in_sof  in  1  beat is first pixel of a frame
- red, green, blue  in  8 each  pixel components
- wr_en  out  1  frame-buffer write strobe
- wr_addr  out  ADDR_W  raster address, row*IMAGEX+col
- wr_data  out  8  intensity value
- frame_ready  out  1  full frame written; buffer owned by dither engine
- frame_ack  in  1  dither engine done with the buffer
- sof_err  out  1  sticky: in_sof seen mid-frame

## Operation
- A beat is accepted when in_valid & in_ready at a rising edge.
- States:
  - IDLE: in_ready=1. Accepted beats without in_sof are discarded. An accepted beat with in_sof becomes pixel 0, and the state moves to LOAD.
  - LOAD: in_ready=1. Each accepted beat takes the next address. When pixel 2**ADDR_W-1 is accepted, the state moves to DRAIN.
  - DRAIN: in_ready=0. The state waits until the pipeline is empty, then moves to FULL.
  - FULL: in_ready=0 and frame_ready=1. frame_ack moves the state to IDLE.
- An in_sof beat accepted in LOAD restarts the pixel counter: that beat is written to address 0. sof_err is set and stays set until rst.
- frame_ack is ignored in every state except FULL.
- Pixel counter is ADDR_W bits. It is reset to 0 on every accepted sof beat and never wraps past the last pixel, because LOAD exits at the last pixel.
- Intensity: Y = (77*R + 150*G + 29*B) >> 8.
  - Computed in 16 bits unsigned; the maximum sum is 65280, so it cannot overflow.
  - Result is the upper byte. No rounding and no saturation are needed.

## Timing
- Reset values:
  - in_ready=0 during rst; 1 on the first cycle after rst (IDLE).
  - wr_en=0, wr_addr=0, wr_data=0, frame_ready=0, sof_err=0.
  - State IDLE; pipeline valid bits cleared.
- Pipeline has two register stages:
  - Stage 1 registers the three products and the address.
  - Stage 2 registers the sum/shift and drives wr_en, wr_addr and wr_data.
  - A beat accepted at edge k produces wr_en high for exactly the cycle after edge k+2.
- Throughput is one pixel per clock while in_valid is held high, with no bubbles inside a frame.
- The last pixel is accepted at edge k. Its wr_en is seen after k+2. frame_ready rises after edge k+3.
- frame_ack sampled high at edge m while in FULL:
  - frame_ready drops after edge m.
  - in_ready rises after edge m.
  - A beat can be accepted at edge m+1 at the earliest.
- rst mid-frame: any in-flight beats never produce wr_en; all state is cleared as in reset. The buffer contents are left undefined.
- in_valid with in_ready=0 is not accepted. The upstream source must hold the beat.

## Configuration
- RGB_LOADER_LUMA_EN
  - Defined: wr_data is the weighted intensity above.
  - Undefined: wr_data = red; green and blue are ignored, and the multipliers are not built.
  - Pipeline latency stays two cycles in both builds (stage 1 registers red directly).

## Test plan
- After rst, one sof beat R=255,G=0,B=0 → wr_en two cycles later, wr_addr=0, wr_data=76. With RGB_LOADER_LUMA_EN undefined, wr_data=255.
- Single-channel beats G=255 (others 0) → 149; B=255 → 28; R=G=B=255 → 255; R=G=B=0xAA → 0xAA.
- Full frame of 4096 back-to-back beats, in_valid held high:
  - 4096 writes at addresses 0..4095 in order, with no gaps.
  - in_ready drops after the 4096th beat.
  - frame_ready rises 3 cycles after the last accept.
  - Extra beats are not accepted while in_ready=0.
- Assert frame_ack one cycle before frame_ready rises → ignored. Assert frame_ack once in FULL → frame_ready drops and in_ready=1 the next cycle.
- Non-sof beats in IDLE → no wr_en. In LOAD at pixel 100, send an sof beat → written at address 0, sof_err=1 and held.
- Assert rst one cycle after accepting a beat → no wr_en follows. All outputs return to their reset values.
